// File: rtl/memory_access.sv
// Memory-access stage: forwards ALU results, resolves branches and runs one
// data-memory transaction at a time over a request/ack bus with a timeout.
module memory_access #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_w,
  input  logic        zero,
  input  logic [31:0] PC_sum,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        branch,
  input  logic [2:0]  funct3,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic        wb_valid,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_valid_q, wb_valid_d;
  logic        pc_src_q, pc_src_d;
  logic [31:0] branch_target_q, branch_target_d;
  logic        misalign_err_q, misalign_err_d;
  logic        bus_err_q, bus_err_d;
  // Access context kept for the completion cycle.
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] result_q, result_d;

  logic        is_mem;
  logic        funct_ok;
  logic        align_ok;
  logic        illegal;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;

  // Pull the addressed byte/halfword out of the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
    logic [31:0] s;
    s = w >> {lane, 3'b000};
    case (f3)
      3'b000:  load_extract = {{24{s[7]}}, s[7:0]};
      3'b100:  load_extract = {24'b0, s[7:0]};
      3'b001:  load_extract = {{16{s[15]}}, s[15:0]};
      3'b101:  load_extract = {16'b0, s[15:0]};
      default: load_extract = w;
    endcase
  endfunction

  // Classify the presented op and build lane-aligned enables and write data.
  always_comb begin
    is_mem = mem_read | mem_write;
    if (mem_read)
      funct_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
    else
      funct_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    case (funct3[1:0])
      2'b01:   align_ok = ~alu_result[0];
      2'b10:   align_ok = (alu_result[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    illegal = is_mem & ((mem_read & mem_write) | ~funct_ok | ~align_ok);
    case (funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << alu_result[1:0];
        wdata_new = {4{rs2_w[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << alu_result[1:0];
        wdata_new = {2{rs2_w[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = rs2_w;
      end
    endcase
  end

  // Next-state logic for the IDLE/BUSY controller and all registered outputs.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    dmem_req_d      = dmem_req_q;
    dmem_we_d       = dmem_we_q;
    dmem_addr_d     = dmem_addr_q;
    dmem_be_d       = dmem_be_q;
    dmem_wdata_d    = dmem_wdata_q;
    wb_data_d       = wb_data_q;
    wb_valid_d      = 1'b0;
    misalign_err_d  = 1'b0;
    bus_err_d       = 1'b0;
    funct3_d        = funct3_q;
    lane_d          = lane_q;
    result_d        = result_q;
    pc_src_d        = in_valid & branch & zero;
    branch_target_d = PC_sum;
    stall           = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            wb_data_d  = alu_result;
            wb_valid_d = 1'b1;
          end else if (illegal) begin
            misalign_err_d = 1'b1;
          end else begin
            stall        = 1'b1;
            state_d      = BUSY;
            cnt_d        = '0;
            dmem_req_d   = 1'b1;
            dmem_we_d    = mem_write;
            dmem_addr_d  = {alu_result[31:2], 2'b00};
            dmem_be_d    = be_new;
            dmem_wdata_d = wdata_new;
            funct3_d     = funct3;
            lane_d       = alu_result[1:0];
            result_d     = alu_result;
          end
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          // Ack wins even on the final timeout cycle.
          state_d    = IDLE;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          dmem_be_d  = 4'b0000;
          wb_valid_d = 1'b1;
          wb_data_d  = dmem_we_q ? result_q : load_extract(dmem_rdata, lane_q, funct3_q);
        end else if (cnt_q == CNT_LAST) begin
          stall      = 1'b1;
          state_d    = IDLE;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          dmem_be_d  = 4'b0000;
          bus_err_d  = 1'b1;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      dmem_req_q      <= 1'b0;
      dmem_we_q       <= 1'b0;
      dmem_addr_q     <= '0;
      dmem_be_q       <= '0;
      dmem_wdata_q    <= '0;
      wb_data_q       <= '0;
      wb_valid_q      <= 1'b0;
      pc_src_q        <= 1'b0;
      branch_target_q <= '0;
      misalign_err_q  <= 1'b0;
      bus_err_q       <= 1'b0;
      funct3_q        <= '0;
      lane_q          <= '0;
      result_q        <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      dmem_req_q      <= dmem_req_d;
      dmem_we_q       <= dmem_we_d;
      dmem_addr_q     <= dmem_addr_d;
      dmem_be_q       <= dmem_be_d;
      dmem_wdata_q    <= dmem_wdata_d;
      wb_data_q       <= wb_data_d;
      wb_valid_q      <= wb_valid_d;
      pc_src_q        <= pc_src_d;
      branch_target_q <= branch_target_d;
      misalign_err_q  <= misalign_err_d;
      bus_err_q       <= bus_err_d;
      funct3_q        <= funct3_d;
      lane_q          <= lane_d;
      result_q        <= result_d;
    end
  end

  assign wb_data       = wb_data_q;
  assign wb_valid      = wb_valid_q;
  assign pc_src        = pc_src_q;
  assign branch_target = branch_target_q;
  assign misalign_err  = misalign_err_q;
  assign bus_err       = bus_err_q;
  assign dmem_req      = dmem_req_q;
  assign dmem_we       = dmem_we_q;
  assign dmem_addr     = dmem_addr_q;
  assign dmem_be       = dmem_be_q;
  assign dmem_wdata    = dmem_wdata_q;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed vector table, random ops against a
// behavioural model, and hand sequences for reset/ack corner cases.
module tb_memory_access;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] rs2_w = '0;
  logic        zero = 1'b0;
  logic [31:0] PC_sum = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        branch = 1'b0;
  logic [2:0]  funct3 = '0;
  logic        stall;
  logic [31:0] wb_data;
  logic        wb_valid;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        misalign_err;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;

  int checks = 0;
  int errors = 0;

  memory_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
    .rs2_w(rs2_w), .zero(zero), .PC_sum(PC_sum), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .funct3(funct3), .stall(stall),
    .wb_data(wb_data), .wb_valid(wb_valid), .pc_src(pc_src),
    .branch_target(branch_target), .misalign_err(misalign_err),
    .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  // kind: 0 = ALU op, 1 = misaligned/illegal, 2 = completed access, 3 = timeout
  typedef struct {
    bit          mr;
    bit          mw;
    bit          br;
    bit          z;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] pcs;
    logic [31:0] rdata;
    int          dly;
    int          kind;
    logic [31:0] exp_wb;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    bit          exp_pc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: derives all expectations from the access rules directly.
  function automatic vec_t model(input vec_t v);
    int sz;
    int lo;
    bit legal;
    logic [31:0] x;
    v.exp_pc = v.br & v.z;
    if (!v.mr && !v.mw) begin
      v.kind = 0;
      v.exp_wb = v.alu;
      return v;
    end
    legal = (v.mr != v.mw);
    if (v.mr) legal = legal && (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else      legal = legal && (v.f3 inside {3'd0, 3'd1, 3'd2});
    sz = 1 << (int'(v.f3) % 4);
    if (v.alu % sz != 0) legal = 0;
    if (!legal) begin
      v.kind = 1;
      return v;
    end
    lo = int'(v.alu % 4);
    v.exp_be = 4'(((1 << sz) - 1) << lo);
    if (sz == 1)      v.exp_wd = v.rs2[7:0] * 32'h01010101;
    else if (sz == 2) v.exp_wd = v.rs2[15:0] * 32'h00010001;
    else              v.exp_wd = v.rs2;
    v.kind = (v.dly >= TO) ? 3 : 2;
    if (v.mw) begin
      v.exp_wb = v.alu;
    end else begin
      x = v.rdata >> (8 * lo);
      if (sz == 1) begin
        x = x % 256;
        if (v.f3 == 3'd0 && x >= 128) x = x - 256;
      end else if (sz == 2) begin
        x = x % 65536;
        if (v.f3 == 3'd1 && x >= 32768) x = x - 65536;
      end
      v.exp_wb = x;
    end
    return v;
  endfunction

  // Apply one op starting just after a rising edge; returns just after an edge.
  task automatic run_op(input vec_t v);
    $display("op kind=%0d rd=%0d wr=%0d f3=%0d addr=%h rs2=%h dly=%0d", v.kind, v.mr, v.mw, v.f3, v.alu, v.rs2, v.dly);
    in_valid = 1'b1; mem_read = v.mr; mem_write = v.mw; branch = v.br; zero = v.z;
    funct3 = v.f3; alu_result = v.alu; rs2_w = v.rs2; PC_sum = v.pcs;
    #1;
    if (v.kind == 0) begin
      chk("alu_stall", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      chk("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
      chk("alu_wb_data", wb_data, v.exp_wb);
      chk("pc_src", {31'b0, pc_src}, {31'b0, v.exp_pc});
      chk("branch_target", branch_target, v.pcs);
      in_valid = 1'b0;
    end else if (v.kind == 1) begin
      chk("mis_stall", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      chk("misalign_err", {31'b0, misalign_err}, 32'd1);
      chk("mis_req", {31'b0, dmem_req}, 32'd0);
      chk("mis_wb_valid", {31'b0, wb_valid}, 32'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("misalign_pulse", {31'b0, misalign_err}, 32'd0);
    end else begin
      chk("issue_stall", {31'b0, stall}, 32'd1);
      @(posedge clk); #1;
      chk("busy_req", {31'b0, dmem_req}, 32'd1);
      chk("busy_addr", dmem_addr, {v.alu[31:2], 2'b00});
      chk("busy_we", {31'b0, dmem_we}, {31'b0, v.mw});
      if (v.mw) begin
        chk("store_be", {28'b0, dmem_be}, {28'b0, v.exp_be});
        chk("store_wdata", dmem_wdata, v.exp_wd);
      end
      for (int k = 0; k < TO; k++) begin
        if (k == v.dly) begin
          dmem_ack = 1'b1; dmem_rdata = v.rdata;
          #1;
          chk("ack_stall", {31'b0, stall}, 32'd0);
          @(posedge clk); #1;
          dmem_ack = 1'b0;
          chk("done_wb_valid", {31'b0, wb_valid}, 32'd1);
          chk("done_wb_data", wb_data, v.exp_wb);
          chk("done_req", {31'b0, dmem_req}, 32'd0);
          in_valid = 1'b0;
          return;
        end
        dmem_rdata = $urandom;
        #1;
        chk("busy_stall", {31'b0, stall}, 32'd1);
        if (k > 0) chk("busy_hold_addr", dmem_addr, {v.alu[31:2], 2'b00});
        @(posedge clk); #1;
      end
      chk("bus_err", {31'b0, bus_err}, 32'd1);
      chk("to_req", {31'b0, dmem_req}, 32'd0);
      chk("to_wb_valid", {31'b0, wb_valid}, 32'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("bus_err_pulse", {31'b0, bus_err}, 32'd0);
    end
  endtask

  vec_t tbl[17];
  vec_t v;

  initial begin
    //          mr mw br z  f3    alu            rs2            pcs       rdata          dly kind exp_wb        be       wd             pc
    tbl[0]  = '{0, 0, 0, 0, 3'd0, 32'h00001234, 32'h0,         32'h0,    32'h0,         0,  0,  32'h00001234, 4'h0,    32'h0,         0};
    tbl[1]  = '{1, 0, 0, 0, 3'd0, 32'h00000103, 32'h0,         32'h0,    32'h80FFFF7F,  2,  2,  32'hFFFFFF80, 4'h0,    32'h0,         0};
    tbl[2]  = '{0, 1, 0, 0, 3'd1, 32'h00000202, 32'hAAAABEEF,  32'h0,    32'h0,         0,  2,  32'h00000202, 4'b1100, 32'hBEEFBEEF,  0};
    tbl[3]  = '{1, 0, 0, 0, 3'd2, 32'h00000006, 32'h0,         32'h0,    32'h0,         0,  1,  32'h0,        4'h0,    32'h0,         0};
    tbl[4]  = '{1, 0, 0, 0, 3'd2, 32'h00000040, 32'h0,         32'h0,    32'h0,         16, 3,  32'h0,        4'h0,    32'h0,         0};
    tbl[5]  = '{0, 0, 1, 1, 3'd0, 32'h00000055, 32'h0,         32'h400,  32'h0,         0,  0,  32'h00000055, 4'h0,    32'h0,         1};
    tbl[6]  = '{0, 0, 1, 0, 3'd0, 32'h00000066, 32'h0,         32'h400,  32'h0,         0,  0,  32'h00000066, 4'h0,    32'h0,         0};
    tbl[7]  = '{1, 0, 0, 0, 3'd4, 32'h00000101, 32'h0,         32'h0,    32'h12348056,  1,  2,  32'h00000080, 4'h0,    32'h0,         0};
    tbl[8]  = '{1, 0, 0, 0, 3'd1, 32'h00000102, 32'h0,         32'h0,    32'h80010000,  0,  2,  32'hFFFF8001, 4'h0,    32'h0,         0};
    tbl[9]  = '{1, 0, 0, 0, 3'd5, 32'h00000102, 32'h0,         32'h0,    32'h80010000,  0,  2,  32'h00008001, 4'h0,    32'h0,         0};
    tbl[10] = '{0, 1, 0, 0, 3'd0, 32'h00000301, 32'h12345655,  32'h0,    32'h0,         0,  2,  32'h00000301, 4'b0010, 32'h55555555,  0};
    tbl[11] = '{0, 1, 0, 0, 3'd2, 32'h00000400, 32'hDEADBEEF,  32'h0,    32'h0,         1,  2,  32'h00000400, 4'b1111, 32'hDEADBEEF,  0};
    tbl[12] = '{1, 1, 0, 0, 3'd2, 32'h00000010, 32'h0,         32'h0,    32'h0,         0,  1,  32'h0,        4'h0,    32'h0,         0};
    tbl[13] = '{1, 0, 0, 0, 3'd3, 32'h00000010, 32'h0,         32'h0,    32'h0,         0,  1,  32'h0,        4'h0,    32'h0,         0};
    tbl[14] = '{0, 1, 0, 0, 3'd4, 32'h00000010, 32'h0,         32'h0,    32'h0,         0,  1,  32'h0,        4'h0,    32'h0,         0};
    tbl[15] = '{1, 0, 0, 0, 3'd2, 32'h00000010, 32'h0,         32'h0,    32'hCAFEF00D,  15, 2,  32'hCAFEF00D, 4'h0,    32'h0,         0};
    tbl[16] = '{1, 0, 0, 0, 3'd1, 32'h00000101, 32'h0,         32'h0,    32'h0,         0,  1,  32'h0,        4'h0,    32'h0,         0};

    // Asynchronous reset: outputs clear before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_we_be", {27'b0, dmem_we, dmem_be}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wb", {wb_data[31:1], wb_data[0] | wb_valid}, 32'd0);
    chk("rst_branch", {branch_target[31:1], branch_target[0] | pc_src}, 32'd0);
    chk("rst_errs", {30'b0, misalign_err, bus_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed table; consecutive entries also exercise back-to-back issue.
    foreach (tbl[i]) run_op(tbl[i]);

    // Randomised ops checked against the model.
    for (int n = 0; n < 60; n++) begin
      int cat;
      v = '{default: '0};
      cat = $urandom_range(0, 3);
      v.alu = $urandom;
      if ($urandom_range(0, 1) == 1) v.alu[1:0] = 2'b00;
      v.rs2 = $urandom; v.rdata = $urandom; v.pcs = $urandom;
      v.dly = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 4);
      case (cat)
        0: begin v.br = 1'($urandom_range(0, 1)); v.z = 1'($urandom_range(0, 1)); end
        1: begin
          v.mr = 1;
          case ($urandom_range(0, 4))
            0: v.f3 = 3'd0; 1: v.f3 = 3'd1; 2: v.f3 = 3'd2; 3: v.f3 = 3'd4; default: v.f3 = 3'd5;
          endcase
        end
        2: begin v.mw = 1; v.f3 = 3'($urandom_range(0, 2)); end
        default: begin
          v.mr = 1'($urandom_range(0, 1)); v.mw = 1'($urandom_range(0, 1));
          v.f3 = 3'($urandom_range(0, 7));
        end
      endcase
      v = model(v);
      run_op(v);
    end

    // Ack while idle must be ignored.
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("idle_ack_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("idle_ack_req", {31'b0, dmem_req}, 32'd0);

    // Reset during BUSY abandons the access; a late ack is ignored.
    in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; branch = 1'b0;
    funct3 = 3'd2; alu_result = 32'h0000_0800;
    @(posedge clk); #1;
    chk("pre_rst_req", {31'b0, dmem_req}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("async_rst_req", {31'b0, dmem_req}, 32'd0);
    chk("async_rst_addr", dmem_addr, 32'd0);
    chk("async_rst_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("late_ack_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("late_ack_req", {31'b0, dmem_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum BUSY cycles to wait for dmem_ack before aborting.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-003 The ports SHALL be (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- in_valid  in  1  execute-stage outputs valid this cycle
- alu_result  in  32  effective address, or ALU value for non-memory ops
- rs2_w  in  32  store data
- zero  in  1  ALU zero flag
- PC_sum  in  32  branch target
- mem_read  in  1  load op
- mem_write  in  1  store op
- branch  in  1  conditional-branch op
- funct3  in  3  access size/sign
- stall  out  1  hold execute-stage inputs stable
- wb_data  out  32  load data or alu_result
- wb_valid  out  1  wb_data valid (1-cycle pulse)
- pc_src  out  1  take branch (1-cycle pulse)
- branch_target  out  32  registered PC_sum
- misalign_err  out  1  misaligned/illegal access (1-cycle pulse)
- bus_err  out  1  ack timeout (1-cycle pulse)
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address {alu_result[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned write data
- dmem_ack  in  1  bus completion
- dmem_rdata  in  32  read word

Function
REQ-004 The FSM SHALL have two states, IDLE and BUSY.
REQ-005 In IDLE, with in_valid=1 and no memory op, the block SHALL register wb_data=alu_result and wb_valid=1 on the next edge (latency 1), with stall=0.
REQ-006 Registered pc_src SHALL equal in_valid & branch & zero; branch_target SHALL be PC_sum registered on the same edge.
REQ-007 Misalignment SHALL be defined as: halfword with alu_result[0]=1; word with alu_result[1:0]!=0; funct3 outside {000,001,010,100,101} for loads or {000,001,010} for stores; mem_read=mem_write=1.
REQ-008 A misaligned or illegal op in IDLE SHALL pulse misalign_err for one cycle, issue no bus request, leave wb_valid=0, and remain in IDLE.
REQ-009 A legal memory op in IDLE SHALL assert stall combinationally in the same cycle and move to BUSY on the next edge, latching address, we, be and wdata.
REQ-010 In BUSY:
- dmem_req=1; dmem_addr, dmem_we, dmem_be and dmem_wdata held stable.
- stall=1 in every cycle with dmem_ack=0.
- stall=0 in the cycle dmem_ack=1.
REQ-011 On dmem_ack in BUSY, the block SHALL return to IDLE on that edge and pulse wb_valid=1 for one cycle.
- Loads: wb_data = extracted load data.
- Stores: wb_data = alu_result.
REQ-012 Store encoding SHALL be:
- SB: be=4'b0001<<addr[1:0], wdata={4{rs2_w[7:0]}}.
- SH: be=4'b0011<<addr[1:0], wdata={2{rs2_w[15:0]}}.
- SW: be=4'b1111, wdata=rs2_w.
REQ-013 Load extraction SHALL select the byte/halfword lane by addr[1:0].
- LB/LH: sign-extend to 32 bits.
- LBU/LHU: zero-extend to 32 bits.
- LW: full word.
REQ-014 A cycle counter SHALL clear on BUSY entry and increment each BUSY cycle without ack.
- When the counter reaches TIMEOUT_CYCLES-1 without ack, the block SHALL drop dmem_req, pulse bus_err, return to IDLE and leave wb_valid=0.
- An ack in that same cycle SHALL win over the timeout.
REQ-015 dmem_ack received in IDLE SHALL be ignored.
REQ-016 A new op SHALL be accepted in the IDLE cycle immediately after a completion, giving back-to-back throughput of one access per two cycles minimum.

Reset
REQ-017 rst=1 SHALL immediately, without waiting for a clock edge, force the following:
- state=IDLE, counter=0.
- dmem_req=0, dmem_we=0, dmem_be=0.
- dmem_addr=0, dmem_wdata=0.
- wb_data=0, wb_valid=0.
- pc_src=0, branch_target=0.
- misalign_err=0, bus_err=0.
REQ-018 Reset during BUSY SHALL abandon the transaction; an ack arriving after reset release SHALL be ignored.

Verification
REQ-019 ALU op: alu_result=0x1234, in_valid=1, no memory op -> next cycle wb_data=0x1234, wb_valid=1, stall never 1.
REQ-020 LB: addr=0x103, dmem_rdata=0x80FF_FF7F, ack after 3 cycles ->
- dmem_addr=0x100; stall high for 3 cycles.
- wb_data=0xFFFF_FF80 (byte 3 = 0x80, sign-extended).
REQ-021 SH: addr=0x202, rs2_w=0xAAAA_BEEF, immediate ack -> dmem_be=4'b1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1.
REQ-022 LW at addr=0x6 -> misalign_err=1 for one cycle, dmem_req stays 0, wb_valid=0.
REQ-023 Load with ack never arriving, TIMEOUT_CYCLES=16 -> bus_err pulses in BUSY cycle 16, dmem_req deasserts, FSM returns to IDLE.
REQ-024 branch=1, zero=1, PC_sum=0x400 -> next cycle pc_src=1, branch_target=0x400; with zero=0 -> pc_src=0.
